mem_port_arbiter: RTL and testbench

- Two-requester arbiter that shares the single Data_Memory port (256-bit line, enable/write/ack handshake) between the instruction-fetch line buffer (port 0) and the L1 data cache miss/write-back engine (port 1).
- Grants one whole transaction at a time with round-robin fairness and holds the memory request stable until ack.
- Returns the response to the granted port; a watchdog aborts transactions that never receive an ack.
- Sits in CPU between the requesters and the top-level mem_*_o / mem_*_i pins.

---
 rtl/mem_port_arbiter.sv | 161 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the shared Data_Memory line port.
// Port 0 is the instruction-fetch line buffer, port 1 the L1 data cache
// miss/write-back engine. One whole transaction is granted at a time with
// round-robin tie-breaking. A watchdog aborts transactions that never see
// an ack.
`timescale 1ns/1ps

module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_enable_i,
    input  logic              m0_write_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_enable_i,
    input  logic              m1_write_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              grant_o,
    output logic              busy_o,
    output logic              timeout_o
);

    // The watchdog counter only has to reach TIMEOUT-1. Abort happens on the
    // edge that ends the TIMEOUT-th BUSY cycle.
    localparam int unsigned CNT_W = (TIMEOUT > 32'd1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] WD_LAST =
        (TIMEOUT > 32'd0) ? CNT_W'(TIMEOUT - 32'd1) : {CNT_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    logic             last_grant_r;
    logic [CNT_W-1:0] wd_cnt_r;

    logic req_any_s;
    logic pick_s;
    logic wd_hit_s;

    // Arbitration choice and watchdog expiry, evaluated every cycle.
    always_comb begin
        req_any_s = m0_enable_i | m1_enable_i;
        pick_s    = 1'b0;
        wd_hit_s  = 1'b0;
        if (m0_enable_i && m1_enable_i) begin
            pick_s = ~last_grant_r;
        end else begin
            pick_s = m1_enable_i;
        end
        if (TIMEOUT != 32'd0) begin
            wd_hit_s = (wd_cnt_r == WD_LAST);
        end else begin
            wd_hit_s = 1'b0;
        end
    end

    // Transaction FSM. All outputs are registered here.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            last_grant_r <= 1'b1;
            wd_cnt_r     <= {CNT_W{1'b0}};
            grant_o      <= 1'b0;
            busy_o       <= 1'b0;
            timeout_o    <= 1'b0;
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= {ADDR_W{1'b0}};
            mem_data_o   <= {DATA_W{1'b0}};
            m0_ack_o     <= 1'b0;
            m1_ack_o     <= 1'b0;
            m0_data_o    <= {DATA_W{1'b0}};
            m1_data_o    <= {DATA_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        state_r      <= ST_BUSY;
                        grant_o      <= pick_s;
                        last_grant_r <= pick_s;
                        busy_o       <= 1'b1;
                        wd_cnt_r     <= {CNT_W{1'b0}};
                        mem_enable_o <= 1'b1;
                        mem_write_o  <= pick_s ? m1_write_i : m0_write_i;
                        mem_addr_o   <= pick_s ? m1_addr_i  : m0_addr_i;
                        mem_data_o   <= pick_s ? m1_data_i  : m0_data_i;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    // Requester inputs are not looked at here, so a dropped
                    // enable cannot cancel a transaction already on the bus.
                    if (mem_ack_i) begin
                        state_r      <= ST_RESP;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                        if (grant_o) begin
                            m1_ack_o  <= 1'b1;
                            m1_data_o <= mem_data_i;
                        end else begin
                            m0_ack_o  <= 1'b1;
                            m0_data_o <= mem_data_i;
                        end
                    end else if (wd_hit_s) begin
                        state_r      <= ST_RESP;
                        mem_enable_o <= 1'b0;
                        mem_write_o  <= 1'b0;
                        timeout_o    <= 1'b1;
                        if (grant_o) begin
                            m1_ack_o  <= 1'b1;
                            m1_data_o <= {DATA_W{1'b0}};
                        end else begin
                            m0_ack_o  <= 1'b1;
                            m0_data_o <= {DATA_W{1'b0}};
                        end
                    end else begin
                        wd_cnt_r <= wd_cnt_r + CNT_W'(1'b1);
                    end
                end
                ST_RESP: begin
                    // The requester still holds its enable in this cycle, so
                    // no arbitration happens until IDLE.
                    state_r   <= ST_IDLE;
                    busy_o    <= 1'b0;
                    timeout_o <= 1'b0;
                    m0_ack_o  <= 1'b0;
                    m1_ack_o  <= 1'b0;
                end
                default: begin
                    state_r      <= ST_IDLE;
                    busy_o       <= 1'b0;
                    timeout_o    <= 1'b0;
                    mem_enable_o <= 1'b0;
                    mem_write_o  <= 1'b0;
                    m0_ack_o     <= 1'b0;
                    m1_ack_o     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests, memory stub,
// and a monitor that checks every port ack against queued expectations.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 256;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          m0_enable_i = 1'b0, m0_write_i = 1'b0;
    logic [AW-1:0] m0_addr_i = '0;
    logic [DW-1:0] m0_data_i = '0;
    logic          m0_ack_o;
    logic [DW-1:0] m0_data_o;
    logic          m1_enable_i = 1'b0, m1_write_i = 1'b0;
    logic [AW-1:0] m1_addr_i = '0;
    logic [DW-1:0] m1_data_i = '0;
    logic          m1_ack_o;
    logic [DW-1:0] m1_data_o;
    logic          mem_enable_o, mem_write_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_data_o;
    logic          mem_ack_i = 1'b0;
    logic [DW-1:0] mem_data_i = '0;
    logic          grant_o, busy_o, timeout_o;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_enable_i(m0_enable_i), .m0_write_i(m0_write_i), .m0_addr_i(m0_addr_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_enable_i(m1_enable_i), .m1_write_i(m1_write_i), .m1_addr_i(m1_addr_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i),
        .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          port;
        logic [DW-1:0] data;
        logic          chk_data;
        logic          tmo;
    } exp_t;

    localparam logic [DW-1:0] LINE00 =
        256'h0000_1111_2222_3333_4444_5555_6666_7777_8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF;
    localparam logic [DW-1:0] LINE20 =
        256'h8888_9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_7777_6666_5555_4444_3333_2222_1111_0000;
    localparam logic [DW-1:0] ECFA = {16{16'hECFA}};

    exp_t          sb_q[$];
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] mem [logic [AW-1:0]];
    int            lat = 10;
    bit            stub_en = 1'b1;
    int            stub_cnt = 0;
    int            en_cnt = 0;
    int            cyc = 0;
    int            last_ack_cyc = -100;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic p, input logic [DW-1:0] d, input logic cd, input logic t);
        exp_t e;
        e.port = p; e.data = d; e.chk_data = cd; e.tmo = t;
        sb_q.push_back(e);
    endtask

    task automatic raise(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            m0_enable_i = 1'b1; m0_write_i = w; m0_addr_i = a; m0_data_i = d;
        end else begin
            m1_enable_i = 1'b1; m1_write_i = w; m1_addr_i = a; m1_data_i = d;
        end
    endtask

    task automatic drop(input int p);
        if (p == 0) m0_enable_i = 1'b0;
        else        m1_enable_i = 1'b0;
    endtask

    task automatic wait_ack(input int p);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if ((p == 0 && m0_ack_o) || (p == 1 && m1_ack_o)) return;
        end
        total++; bad++;
        $display("FAIL wait_ack: port %0d got no ack within 400 cycles", p);
    endtask

    task automatic serve(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk_i);
        raise(p, w, a, d);
        wait_ack(p);
        drop(p);
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b1; drop(0); drop(1);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_enable"}, mem_enable_o, 0);
        check({tag, "_mem_write"},  mem_write_o, 0);
        check({tag, "_mem_addr"},   mem_addr_o, 0);
        check({tag, "_mem_data"},   mem_data_o, 0);
        check({tag, "_grant"},      grant_o, 0);
        check({tag, "_busy"},       busy_o, 0);
        check({tag, "_timeout"},    timeout_o, 0);
        check({tag, "_acks"},       {m0_ack_o, m1_ack_o}, 0);
        check({tag, "_m0_data"},    m0_data_o, 0);
        check({tag, "_m1_data"},    m1_data_o, 0);
    endtask

    always @(posedge clk_i) cyc = cyc + 1;

    // Memory stub: acks 'lat' enabled cycles after the request (0 = never).
    always @(negedge clk_i) begin
        if (stub_en) begin
            if (mem_ack_i) begin
                mem_ack_i = 1'b0;
                stub_cnt  = 0;
            end else if (mem_enable_o) begin
                stub_cnt++;
                en_cnt++;
                if (lat != 0 && stub_cnt == lat) begin
                    mem_ack_i = 1'b1;
                    if (mem_write_o) mem[mem_addr_o] = mem_data_o;
                    else mem_data_i = mem.exists(mem_addr_o) ? mem[mem_addr_o] : '0;
                end
            end else begin
                stub_cnt = 0;
            end
        end
    end

    // Monitor: every port ack is popped against the scoreboard.
    always @(negedge clk_i) begin : mon
        exp_t e;
        logic p;
        if (m0_ack_o || m1_ack_o) begin
            p = m1_ack_o;
            check("single_ack", {m0_ack_o, m1_ack_o} == 2'b11, 0);
            check("ack_spacing", (cyc - last_ack_cyc) > 2, 1);
            last_ack_cyc = cyc;
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_ack: port %0d acked with nothing expected", p);
            end else begin
                e = sb_q.pop_front();
                check("ack_port", p, e.port);
                check("ack_grant", grant_o, e.port);
                check("ack_timeout", timeout_o, e.tmo);
                if (e.chk_data) check("ack_data", p ? m1_data_o : m0_data_o, e.data);
            end
        end else if (timeout_o) begin
            total++; bad++;
            $display("FAIL stray_timeout: timeout_o=1 with no port ack");
        end
    end

    initial begin
        mem[32'h0000_0000] = LINE00;
        mem[32'h0000_0020] = LINE20;
        for (int i = 0; i < 3; i++) begin
            mem[32'h1000 + 32'(i * 32)] = {8{32'hA5A5_0000 + 32'(i)}};
            mem[32'h2000 + 32'(i * 32)] = {8{32'h5A5A_0000 + 32'(i)}};
        end

        // Reset state
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check_zero("reset");

        // Single read on port 0
        lat = 10;
        push(1'b0, LINE00, 1'b1, 1'b0);
        @(negedge clk_i);
        raise(0, 1'b0, 32'h0, '0);
        @(negedge clk_i);
        check("t1_mem_enable", mem_enable_o, 1);
        check("t1_grant", grant_o, 0);
        check("t1_busy", busy_o, 1);
        check("t1_addr", mem_addr_o, 0);
        check("t1_write", mem_write_o, 0);
        wait_ack(0);
        drop(0);

        // Simultaneous requests right after reset: port 0 first
        do_reset();
        push(1'b0, LINE00, 1'b1, 1'b0);
        push(1'b1, LINE20, 1'b1, 1'b0);
        fork
            serve(0, 1'b0, 32'h0, '0);
            serve(1, 1'b0, 32'h20, '0);
        join

        // Continuous contention: strict alternation
        do_reset();
        lat = 3;
        for (int i = 0; i < 3; i++) begin
            push(1'b0, mem[32'h1000 + 32'(i * 32)], 1'b1, 1'b0);
            push(1'b1, mem[32'h2000 + 32'(i * 32)], 1'b1, 1'b0);
        end
        fork
            begin
                for (int i = 0; i < 3; i++) serve(0, 1'b0, 32'h1000 + 32'(i * 32), '0);
            end
            begin
                for (int j = 0; j < 3; j++) serve(1, 1'b0, 32'h2000 + 32'(j * 32), '0);
            end
        join

        // m0 drops enable mid-BUSY; m1 write with inputs changed mid-BUSY
        do_reset();
        lat = 10;
        push(1'b0, LINE00, 1'b1, 1'b0);
        push(1'b1, '0, 1'b0, 1'b0);
        fork
            begin
                @(negedge clk_i);
                raise(0, 1'b0, 32'h0, '0);
                repeat (4) @(negedge clk_i);
                drop(0);
                wait_ack(0);
            end
            begin
                @(negedge clk_i);
                raise(1, 1'b1, 32'h200, ECFA);
                for (int k = 0; k < 200; k++) begin
                    @(negedge clk_i);
                    if (mem_enable_o && grant_o) break;
                end
                repeat (3) @(negedge clk_i);
                m1_data_i = '1; m1_addr_i = 32'h300; m1_write_i = 1'b0;
                @(negedge clk_i);
                check("t4_wr_strobe", mem_write_o, 1);
                check("t4_wr_data", mem_data_o, ECFA);
                check("t4_wr_addr", mem_addr_o, 32'h200);
                wait_ack(1);
                drop(1);
            end
        join
        check("t4_mem_200", mem.exists(32'h200) ? mem[32'h200] : '0, ECFA);

        // Watchdog: no ack ever, then ack on the 64th BUSY cycle
        do_reset();
        lat = 0;
        en_cnt = 0;
        push(1'b0, '0, 1'b1, 1'b1);
        serve(0, 1'b0, 32'h0, '0);
        check("t5_busy_cycles_tmo", en_cnt, 64);
        @(negedge clk_i);
        lat = 64;
        en_cnt = 0;
        push(1'b0, LINE00, 1'b1, 1'b0);
        serve(0, 1'b0, 32'h0, '0);
        check("t5_busy_cycles_ack", en_cnt, 64);

        // Reset mid-transaction, then a stale ack
        do_reset();
        lat = 0;
        @(negedge clk_i);
        raise(0, 1'b0, 32'h0, '0);
        repeat (3) @(negedge clk_i);
        check("t6_in_busy", mem_enable_o, 1);
        stub_en = 1'b0;
        rst_i = 1'b1;
        drop(0);
        @(negedge clk_i);
        rst_i = 1'b0;
        stub_cnt = 0;
        check_zero("t6_midreset");
        repeat (6) @(negedge clk_i);
        mem_data_i = {8{32'hDEAD_BEEF}};
        mem_ack_i = 1'b1;
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("t6_no_stale_ack", {m0_ack_o, m1_ack_o, busy_o}, 0);
        stub_en = 1'b1;
        lat = 10;
        push(1'b0, LINE00, 1'b1, 1'b0);
        serve(0, 1'b0, 32'h0, '0);

        repeat (3) @(negedge clk_i);
        check("sb_empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
